// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around a 64-bit combinational ALU.
// Holds the integer register file and a single EX register that drives the ALU.
// The ALU result is written back on the edge after issue. One forwarding path
// carries a retiring result into an instruction issuing on the same edge.
// Retirement also latches the zero/overflow flags and bumps a retired counter.
//
// Handshake: an instruction on in_* transfers on a rising edge where
// in_valid & in_ready. in_ready is purely combinational (~stall & ~ld_en) and
// never depends on in_valid. The producer must hold its fields stable until the
// transfer happens.
module alu_issue_wb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_funct,
    input  logic            stall,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [1:0]      alu_op,
    output logic [2:0]      alu_funct,
    output logic            alu_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            flag_zero,
    output logic            flag_overflow,
    output logic [31:0]     retired,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [AW-1:0]   r_rd;
    logic            w_issue;
    logic            w_retire;
    logic [XLEN-1:0] w_opa;
    logic [XLEN-1:0] w_opb;

    // The loader owns the write port's second slot, so issue waits for it.
    assign in_ready = ~stall & ~ld_en;
    assign w_issue  = in_valid & in_ready;
    assign w_retire = alu_valid & ~stall;

    // Operand select: x0 reads zero, and a result retiring this edge
    // bypasses the file. rs != 0 already excludes forwarding from rd = 0.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        if (in_rs1 != '0) begin
            if (w_retire && (r_rd == in_rs1)) w_opa = alu_result;
            else                              w_opa = r_regs[in_rs1];
        end
        if (in_rs2 != '0) begin
            if (w_retire && (r_rd == in_rs2)) w_opb = alu_result;
            else                              w_opb = r_regs[in_rs2];
        end
    end

    // EX register: captures on issue, empties when idle, freezes under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_funct <= '0;
            alu_valid <= 1'b0;
            r_rd      <= '0;
        end else if (!stall) begin
            alu_valid <= w_issue;
            if (w_issue) begin
                alu_a     <= w_opa;
                alu_b     <= w_opb;
                alu_op    <= in_op;
                alu_funct <= in_funct;
                r_rd      <= in_rd;
            end
        end
    end

    // Register file: writeback takes priority over the loader on the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_retire && (r_rd == AW'(i)))
                    r_regs[i] <= alu_result;
                else if (ld_en && (ld_addr == AW'(i)))
                    r_regs[i] <= ld_data;
            end
        end
    end

    // Retirement status: flags of the last retired instruction and a wrapping count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero     <= 1'b0;
            flag_overflow <= 1'b0;
            retired       <= '0;
        end else if (w_retire) begin
            flag_zero     <= alu_zero;
            flag_overflow <= alu_overflow;
            retired       <= retired + 32'd1;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a bench-side ALU and a value-level model.
module tb_alu_issue_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [1:0]  in_op;
  logic [2:0]  in_funct;
  logic        stall;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alu_op;
  logic [2:0]  alu_funct;
  logic        alu_valid;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        flag_zero;
  logic        flag_overflow;
  logic [31:0] retired;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  alu_issue_wb dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_op(in_op), .in_funct(in_funct),
    .stall(stall),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_funct(alu_funct),
    .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .flag_zero(flag_zero), .flag_overflow(flag_overflow),
    .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- ALU stand-in (op=10: funct 100 subtracts, else adds)
  function automatic logic [63:0] alu_fn(input logic [1:0] op, input logic [2:0] f,
                                         input logic [63:0] a, input logic [63:0] b);
    if (op == 2'b10 && f == 3'b100) return a - b;
    return a + b;
  endfunction

  function automatic logic alu_ovf(input logic [1:0] op, input logic [2:0] f,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = alu_fn(op, f, a, b);
    if (op == 2'b10 && f == 3'b100) return (a[63] != b[63]) && (r[63] != a[63]);
    return (a[63] == b[63]) && (r[63] != a[63]);
  endfunction

  assign alu_result   = alu_fn(alu_op, alu_funct, alu_a, alu_b);
  assign alu_zero     = (alu_result == 64'd0);
  assign alu_overflow = alu_ovf(alu_op, alu_funct, alu_a, alu_b);

  // ---------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: register values after each edge, plus the EX contents
  logic [63:0] m_regs [32];
  logic [63:0] m_a, m_b;
  logic [1:0]  m_op;
  logic [2:0]  m_funct;
  logic [4:0]  m_rd;
  logic        m_valid, m_fz, m_fo;
  logic [31:0] m_ret;

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] nregs [32];
    logic [63:0] res;
    logic        ret;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_a = 0; m_b = 0; m_op = 0; m_funct = 0; m_rd = 0;
      m_valid = 0; m_fz = 0; m_fo = 0; m_ret = 0;
    end else begin
      ret = m_valid && !stall;
      res = alu_fn(m_op, m_funct, m_a, m_b);
      nregs = m_regs;
      if (ld_en && ld_addr != 0) nregs[ld_addr] = ld_data;
      if (ret && m_rd != 0) nregs[m_rd] = res;
      if (ret) begin
        m_fz  = (res == 64'd0);
        m_fo  = alu_ovf(m_op, m_funct, m_a, m_b);
        m_ret = m_ret + 1;
      end
      if (!stall) begin
        // An issuing instruction sees the file as it stands after this edge.
        if (in_valid && !ld_en) begin
          m_a = (in_rs1 == 0) ? 64'd0 : nregs[in_rs1];
          m_b = (in_rs2 == 0) ? 64'd0 : nregs[in_rs2];
          m_op = in_op; m_funct = in_funct; m_rd = in_rd;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      m_regs = nregs;
    end
  end

  // ---------------- scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("alu_valid", 64'(alu_valid), 64'(m_valid));
      check("in_ready", 64'(in_ready), 64'(!stall && !ld_en));
      check("retired", 64'(retired), 64'(m_ret));
      check("flag_zero", 64'(flag_zero), 64'(m_fz));
      check("flag_overflow", 64'(flag_overflow), 64'(m_fo));
      check("dbg_data", dbg_data, (dbg_addr == 0) ? 64'd0 : m_regs[dbg_addr]);
      if (m_valid) begin
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_op", 64'(alu_op), 64'(m_op));
        check("alu_funct", 64'(alu_funct), 64'(m_funct));
      end
    end
  end

  // ---------------- driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ld(input logic [4:0] a, input logic [63:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask

  task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [1:0] op, input logic [2:0] f);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_op = op; in_funct = f;
    step();
    in_valid = 0;
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] a, input logic [63:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  // ---------------- directed stimulus with literal expectations
  initial begin
    rst_n = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_op = 0; in_funct = 0;
    stall = 0; ld_en = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_alu_valid", 64'(alu_valid), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    rst_n = 1;
    cmp_en = 1;

    // Reset discards loaded state.
    ld(5'd1, 64'd5);
    ld(5'd2, 64'd3);
    dbg_chk("pre_rst_x1", 5'd1, 64'd5);
    rst_n = 0;
    #1;
    dbg_chk("rst_x1", 5'd1, 64'd0);
    check("rst2_retired", 64'(retired), 64'd0);
    check("rst2_alu_valid", 64'(alu_valid), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Basic retire and forwarding, back-to-back.
    ld(5'd1, 64'd5);
    ld(5'd2, 64'd3);
    iss(5'd1, 5'd2, 5'd3, 2'b10, 3'b000);
    check("add_alu_a", alu_a, 64'd5);
    check("add_alu_b", alu_b, 64'd3);
    iss(5'd3, 5'd3, 5'd4, 2'b10, 3'b000);
    check("fwd_alu_a", alu_a, 64'd8);
    check("fwd_alu_b", alu_b, 64'd8);
    check("add_retired", 64'(retired), 64'd1);
    check("add_flag_zero", 64'(flag_zero), 64'd0);
    dbg_chk("add_x3", 5'd3, 64'd8);
    step();
    dbg_chk("fwd_x4", 5'd4, 64'd16);
    check("fwd_retired", 64'(retired), 64'd2);

    // x0: writes to rd=0 are dropped but still retire; rs=0 reads zero.
    iss(5'd1, 5'd2, 5'd0, 2'b10, 3'b000);
    iss(5'd0, 5'd2, 5'd6, 2'b10, 3'b000);
    check("x0_alu_a", alu_a, 64'd0);
    check("x0_alu_b", alu_b, 64'd3);
    check("x0_retired", 64'(retired), 64'd3);
    dbg_chk("x0_reads_zero", 5'd0, 64'd0);
    step();
    dbg_chk("x6", 5'd6, 64'd3);
    check("x0_retired2", 64'(retired), 64'd4);

    // Stall holds a sub in EX; an offered instruction is not accepted.
    iss(5'd1, 5'd1, 5'd5, 2'b10, 3'b100);
    stall = 1;
    in_valid = 1; in_rs1 = 5'd2; in_rs2 = 5'd2; in_rd = 5'd7; in_op = 2'b10; in_funct = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(alu_valid), 64'd1);
      check("stall_alu_a", alu_a, 64'd5);
      check("stall_retired", 64'(retired), 64'd4);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    stall = 0;
    in_valid = 0;
    step();
    dbg_chk("sub_x5", 5'd5, 64'd0);
    check("sub_flag_zero", 64'(flag_zero), 64'd1);
    check("sub_retired", 64'(retired), 64'd5);
    dbg_chk("stall_no_x7", 5'd7, 64'd0);

    // Loader vs writeback: same index -> writeback wins; different -> both land.
    ld(5'd3, 64'd77);
    iss(5'd1, 5'd2, 5'd3, 2'b10, 3'b000);
    ld(5'd3, 64'd99);
    dbg_chk("collide_x3", 5'd3, 64'd8);
    iss(5'd1, 5'd2, 5'd6, 2'b10, 3'b000);
    ld(5'd7, 64'd42);
    dbg_chk("both_x6", 5'd6, 64'd8);
    dbg_chk("both_x7", 5'd7, 64'd42);
    check("both_retired", 64'(retired), 64'd7);

    // Signed overflow on add; flags then hold while idle.
    ld(5'd8, 64'h7FFF_FFFF_FFFF_FFFF);
    ld(5'd9, 64'd1);
    iss(5'd8, 5'd9, 5'd10, 2'b10, 3'b000);
    step();
    check("ovf_flag", 64'(flag_overflow), 64'd1);
    check("ovf_zero", 64'(flag_zero), 64'd0);
    dbg_chk("ovf_x10", 5'd10, 64'h8000_0000_0000_0000);
    step();
    step();
    check("ovf_hold", 64'(flag_overflow), 64'd1);
    check("ovf_retired", 64'(retired), 64'd8);

    // Reset mid-flight drops the EX instruction without writeback.
    iss(5'd1, 5'd2, 5'd11, 2'b10, 3'b000);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(alu_valid), 64'd0);
    check("mid_rst_retired", 64'(retired), 64'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    dbg_chk("mid_rst_x11", 5'd11, 64'd0);
    dbg_chk("mid_rst_x1", 5'd1, 64'd0);
    step();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-issue and writeback stage that sits directly around the 64-bit combinational ALU.
- Holds the 32 x 64-bit integer register file and accepts decoded register-register instructions (rs1, rs2, rd, op, funct) over a valid/ready handshake.
- Registers the operands and control into an EX register that drives the ALU inputs.
- Writes the ALU result back to rd on the following clock edge, with one forwarding path.
- Also latches the zero/overflow flags and counts retired instructions.

Parameters:
- XLEN, 64, datapath width; must match the ALU operand width.
- NREG, 32, register count; address width is log2(NREG) = 5.

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_rs1  input  5  source register 1 index
- in_rs2  input  5  source register 2 index
- in_rd  input  5  destination register index
- in_op  input  2  ALU op field, passed through to the ALU
- in_funct  input  3  ALU funct bits, passed through to the ALU
- stall  input  1  freezes the EX register and blocks writeback
- ld_en  input  1  loader write enable
- ld_addr  input  5  loader write index
- ld_data  input  XLEN  loader write data
- alu_a  output  XLEN  registered operand a
- alu_b  output  XLEN  registered operand b
- alu_op  output  2  registered op
- alu_funct  output  3  registered funct
- alu_valid  output  1  EX register holds a live instruction
- alu_result  input  XLEN  combinational ALU result
- alu_zero  input  1  ALU zero flag
- alu_overflow  input  1  ALU overflow flag
- flag_zero  output  1  zero flag of the last retired instruction
- flag_overflow  output  1  overflow flag of the last retired instruction
- retired  output  32  count of retired instructions
- dbg_addr  input  5  debug read index
- dbg_data  output  XLEN  combinational read of regfile[dbg_addr]; index 0 reads 0

Behaviour:
Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).

Reset:
- While rst_n=0: every register file entry = 0, and alu_a, alu_b, alu_op, alu_funct, alu_valid, flag_zero, flag_overflow, retired are all 0.
- Reset mid-operation discards any in-flight EX instruction without writeback.

Handshake:
- in_ready = ~stall & ~ld_en.
- An instruction issues on an edge where in_valid & in_ready.

Issue (edge N):
- EX register captures the operands and control; alu_valid=1 from N.
- Each operand: if EX is live, is retiring at N, ex_rd != 0 and ex_rd == rs, take alu_result (forward); otherwise take regfile[rs].
- Any rs == 0 yields 0, with no forwarding from rd=0.
- With no issue at an unstalled edge, alu_valid goes to 0.

Writeback:
- At an edge with alu_valid & ~stall: regfile[ex_rd] <= alu_result unless ex_rd = 0.
- Same edge: flag_zero <= alu_zero, flag_overflow <= alu_overflow, retired <= retired + 1 (wraps 2^32-1 -> 0).
- Issue-to-writeback latency is exactly 1 cycle when unstalled; back-to-back issue every cycle is supported.

Stall:
- All EX outputs hold; no writeback, flag update or counter change.
- The held instruction retires on the first edge after stall drops.

Loader:
- ld_en writes regfile[ld_addr] <= ld_data (ld_addr = 0 is ignored).
- Loader and writeback on the same edge to the same index: writeback wins; different indices both commit.
- Loader data is not forwarded; because in_ready=0 during ld_en, the next issue reads the updated file.

Flags:
- flag_zero and flag_overflow hold their values between retirements.

Test Plan:
- Reset check: ld x1=5, x2=3, then assert rst_n=0 mid-sequence; dbg_data(x1)=0, retired=0, alu_valid=0.
- Basic retire: load x1=5, x2=3; issue add x3=x1+x2 (op=10, funct=000); next cycle alu_a=5, alu_b=3; after writeback dbg x3=8, retired=1, flag_zero=0.
- Forwarding: issue x3=x1+x2, then next cycle x4=x3+x3; alu_a=alu_b=8 from forwarding; x4=16 after writeback.
- x0 handling: issue with rd=0 gives x0 still 0, no forward, retired still increments; issue with rs1=0 gives alu_a=0.
- Stall and sub: stall=1 for 3 cycles while a sub x5=x1-x1 (op=10, funct=100 per ALU decode) sits in EX; outputs hold, retired unchanged, in_ready=0; after release x5=0, flag_zero=1.
- Loader/writeback collision: ld_en with ld_addr=3, ld_data=99 on the same edge a writeback to x3=8 commits; x3=8.
